// File: rtl/mux6_rr_arbiter.sv
// Round-robin arbiter that sequences the select of the shared 6:1 mux.
// Grants one requester per burst of up to HOLD cycles; the next winner takes over with no gap cycle.
module mux6_rr_arbiter #(
  parameter int HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] req,
  output logic [5:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       last
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(HOLD - 1);

  state_t     state_reg;
  logic [2:0] idx_reg;
  logic [2:0] ptr_reg;
  logic [3:0] cnt_reg;
  logic [5:0] gnt_reg;

  logic [2:0] end_ptr;
  logic       burst_end;
  logic       found_idle, found_end;
  logic [2:0] win_idle, win_end;

  // Returns {found, winner}: the first set request scanning p, p+1, ... cyclically mod 6.
  // Scanning from the far end lets the nearest hit overwrite earlier ones.
  function automatic logic [3:0] pick(input logic [5:0] r, input logic [2:0] p);
    logic [3:0] res;
    int         j;
    res = '0;
    for (int k = 5; k >= 0; k--) begin
      j = int'(p) + k;
      if (j >= 6) j = j - 6;
      if (r[j]) res = {1'b1, 3'(j)};
    end
    return res;
  endfunction

  always_comb begin
    end_ptr                = (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
    burst_end              = !req[idx_reg] || (cnt_reg == 4'd0);
    {found_idle, win_idle} = pick(req, ptr_reg);
    {found_end, win_end}   = pick(req, end_ptr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= 3'd0;
      ptr_reg   <= 3'd0;
      cnt_reg   <= 4'd0;
      gnt_reg   <= 6'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found_idle) begin
            state_reg <= GRANT;
            idx_reg   <= win_idle;
            gnt_reg   <= 6'b000001 << win_idle;
            cnt_reg   <= CNT_INIT;
          end
        end
        GRANT: begin
          if (burst_end) begin
            ptr_reg <= end_ptr;
            if (found_end) begin
              idx_reg <= win_end;
              gnt_reg <= 6'b000001 << win_end;
              cnt_reg <= CNT_INIT;
            end else begin
              state_reg <= IDLE;
              gnt_reg   <= 6'd0;
            end
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // idx doubles as the mux select; it holds its value through IDLE.
  assign gnt  = gnt_reg;
  assign sel  = idx_reg;
  assign busy = (state_reg == GRANT);
  assign last = (state_reg == GRANT) && (cnt_reg == 4'd0);

endmodule

// File: tb/tb_mux6_rr_arbiter.sv
// Directed bench for mux6_rr_arbiter: one HOLD=4 instance and one HOLD=1 instance.
module tb_mux6_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [5:0] req_a, req_b;
  logic [5:0] gnt_a, gnt_b;
  logic [2:0] sel_a, sel_b;
  logic       busy_a, busy_b, last_a, last_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux6_rr_arbiter #(.HOLD(4)) dut (
    .clk(clk), .rst(rst_a), .req(req_a),
    .gnt(gnt_a), .sel(sel_a), .busy(busy_a), .last(last_a)
  );

  mux6_rr_arbiter #(.HOLD(1)) dut1 (
    .clk(clk), .rst(rst_b), .req(req_b),
    .gnt(gnt_b), .sel(sel_b), .busy(busy_b), .last(last_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observed/expected packed as {last, busy, sel, gnt}.
  task automatic expect_out(input string tag, input bit which,
                            input logic [5:0] g, input logic [2:0] s,
                            input logic b, input logic l);
    if (which)
      check(tag, 32'({last_b, busy_b, sel_b, gnt_b}), 32'({l, b, s, g}));
    else
      check(tag, 32'({last_a, busy_a, sel_a, gnt_a}), 32'({l, b, s, g}));
  endtask

  initial begin
    int order[7] = '{0, 1, 2, 3, 4, 5, 0};
    rst_a = 1'b1; req_a = 6'b111111;
    rst_b = 1'b1; req_b = 6'b100001;

    // Reset with all requests present
    step(); expect_out("reset_c1", 0, 6'd0, 3'd0, 1'b0, 1'b0);
    step(); expect_out("reset_c2", 0, 6'd0, 3'd0, 1'b0, 1'b0);
    rst_a = 1'b0;

    // All channels requesting: 0..5,0 each for 4 cycles, last on the 4th
    foreach (order[n]) begin
      for (int c = 0; c < 4; c++) begin
        step();
        expect_out($sformatf("all_ch%0d_c%0d", order[n], c), 0,
                   6'(1 << order[n]), 3'(order[n]), 1'b1, (c == 3));
      end
    end

    // Single held request on ch3: two back-to-back bursts
    req_a = 6'b001000;
    for (int c = 0; c < 8; c++) begin
      step();
      expect_out($sformatf("hold_ch3_c%0d", c), 0, 6'b001000, 3'd3, 1'b1, (c == 3 || c == 7));
    end
    req_a = 6'b000000;
    step(); expect_out("idle_after_ch3", 0, 6'd0, 3'd3, 1'b0, 1'b0);

    // Early release of ch2 after two granted cycles
    req_a = 6'b000100;
    step(); expect_out("rel_ch2_c0", 0, 6'b000100, 3'd2, 1'b1, 1'b0);
    step(); expect_out("rel_ch2_c1", 0, 6'b000100, 3'd2, 1'b1, 1'b0);
    req_a = 6'b000000;
    step(); expect_out("rel_ch2_idle", 0, 6'd0, 3'd2, 1'b0, 1'b0);

    // ptr=3: ch4 wins before ch1
    req_a = 6'b010010;
    for (int c = 0; c < 4; c++) begin
      step();
      expect_out($sformatf("ptr3_ch4_c%0d", c), 0, 6'b010000, 3'd4, 1'b1, (c == 3));
    end
    step(); expect_out("ptr3_ch1_c0", 0, 6'b000010, 3'd1, 1'b1, 1'b0);

    // Release ch1 with only ch5 requesting, then ch0 rises mid-burst
    req_a = 6'b100000;
    step(); expect_out("wrap_ch5_c0", 0, 6'b100000, 3'd5, 1'b1, 1'b0);
    req_a = 6'b100001;
    for (int c = 1; c < 4; c++) begin
      step();
      expect_out($sformatf("wrap_ch5_c%0d", c), 0, 6'b100000, 3'd5, 1'b1, (c == 3));
    end
    step(); expect_out("wrap_ch0_c0", 0, 6'b000001, 3'd0, 1'b1, 1'b0);

    // Reset in cycle 2 of a ch4 burst
    req_a = 6'b010000;
    step(); expect_out("mid_ch4_c0", 0, 6'b010000, 3'd4, 1'b1, 1'b0);
    step(); expect_out("mid_ch4_c1", 0, 6'b010000, 3'd4, 1'b1, 1'b0);
    rst_a = 1'b1; req_a = 6'b111111;
    step(); expect_out("mid_reset", 0, 6'd0, 3'd0, 1'b0, 1'b0);
    rst_a = 1'b0;
    step(); expect_out("post_reset_ch0", 0, 6'b000001, 3'd0, 1'b1, 1'b0);

    // HOLD=1: ch0/ch5 alternate every cycle with last always high
    rst_b = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (c % 2 == 0)
        expect_out($sformatf("h1_c%0d_ch0", c), 1, 6'b000001, 3'd0, 1'b1, 1'b1);
      else
        expect_out($sformatf("h1_c%0d_ch5", c), 1, 6'b100000, 3'd5, 1'b1, 1'b1);
    end
    req_b = 6'b000000;
    step(); expect_out("h1_idle", 1, 6'd0, 3'd5, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux6_rr_arbiter.md
# mux6_rr_arbiter

Round-robin arbiter and select sequencer for the shared 6:1 multiplexer (`m61`). Six requesters compete for the single mux output. The block grants one requester at a time for a bounded burst and drives the mux select `s[2:0]` directly from its `sel` output. Fairness is by a rotating priority pointer; back-to-back grants have no idle cycle between them.

## Interface
- `HOLD`, default 4: maximum grant length in cycles per burst; legal range 1..8.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  6  request per channel; bit i corresponds to mux data input `din[i]`.
- `gnt`  out 6  one-hot grant; all zero when no channel is granted. Registered.
- `sel`  out 3  mux select; always in 0..5. Registered.
- `busy` out 1  high while any grant is active. Registered.
- `last` out 1  high during the final cycle of a burst that ends on count expiry.

## Operation
- **State:** FSM {IDLE, GRANT}.
  - `idx[2:0]`: currently granted channel.
  - `ptr[2:0]`: highest-priority channel for the next arbitration.
  - `cnt[3:0]`: remaining grant cycles.
- **Arbitration function:** first set bit of `req`, scanning cyclically `ptr, ptr+1, … ptr+5` (mod 6).
- **IDLE**
  - `gnt=0`, `busy=0`, `sel` holds its previous value.
  - If `req != 0`: go to GRANT, `idx` = winner, `sel` = winner, `gnt[winner]` = 1, `cnt` = HOLD-1.
- **GRANT:** each edge, the burst ends if `req[idx]==0` (release) or `cnt==0` (expiry). Otherwise `cnt` decrements.
- **At burst end**
  - `ptr` = (idx+1) mod 6; index 5 wraps to 0.
  - Arbitrate on the current `req` with the new `ptr`.
  - A winner exists: stay in GRANT with a new `idx`/`sel`/`gnt` and `cnt=HOLD-1`, with no gap cycle. The ending channel wins again only if it is the sole requester.
  - No winner: go to IDLE, `gnt=0`, `sel` unchanged.
- `last` = GRANT && `cnt==0`. With HOLD=1, `last` is high on every granted cycle.
- `sel` never takes value 6 or 7. `gnt` is always one-hot or zero. `gnt[sel]==1` whenever `busy==1`.

## Timing
- **Reset values:** `gnt=0`, `sel=0`, `busy=0`, `last=0`, `ptr=0`, `cnt=0`, state IDLE.
  - `req` is ignored on any edge where `rst=1`.
  - Reset mid-burst clears everything at that edge.
- **Grant latency:** `req` sampled high at edge k (from IDLE) → `gnt` and `sel` valid after edge k.
- **Continuous request:** a channel holding `req` receives exactly HOLD consecutive granted cycles.
- **Release:** `req[idx]` sampled low at edge k → `gnt[idx]` drops (or moves to the next channel) after edge k. The cycle in which `req` is low while still granted counts as a granted cycle.
- **Simultaneous events**
  - Requests rising in the cycle a burst ends take part in that arbitration.
  - A release and expiry on the same edge are treated as a single burst end.
- **Changes of `req[j]` for j≠idx** have no effect during a burst.
- **Mux path:** the mux data path is combinational from `sel`, so the `m61` output is valid in the same cycle as `gnt`.

## Test plan
- **Reset with all requests:** `rst=1` for 2 cycles with `req=6'b111111` → `gnt=0`, `sel=0`, `busy=0`, `last=0`. Release `rst` → the next edge grants ch0 (`gnt=6'b000001`, `sel=0`).
- **Single held request:** HOLD=4, `req=6'b001000` held → `gnt=6'b001000`, `sel=3` for 4 cycles with `last` high in the 4th. Then an immediate fresh 4-cycle regrant of ch3, with `busy` never dropping.
- **All channels requesting:** HOLD=4, `req=6'b111111` continuous → grant sequence 0,1,2,3,4,5,0, each 4 cycles, no gaps, `last` every 4th cycle. `sel` matches the one-hot `gnt` on every cycle.
- **Early release:** `req=6'b000100`; drop `req[2]` after 2 granted cycles → `gnt` goes to 0 at the next edge, `busy=0`, `last` never asserted. Then `req=6'b010010` → ch4 granted (ptr=3), followed by ch1.
- **Pointer wrap:** after a ch5 burst with `req=6'b100001` held → ch0 is granted next. With HOLD=1 and `req=6'b100001` held → grants alternate ch0/ch5 every cycle with `last` constantly high.
- **Reset mid-burst:** assert `rst` in cycle 2 of a ch4 burst → all outputs cleared after that edge and `ptr=0`. With `req=6'b111111` after reset → ch0 is granted first.
